sent_tx_slow_sched: RTL and testbench
=====================================

Name: sent_tx_slow_sched

Overview:
Slow-channel message scheduler for the SENT transmitter. It holds NUM_SLOTS serial-message slots, each with an 8-bit ID, 16-bit data and a repeat period counted in SENT frames. It arbitrates pending slots round-robin and offers one message at a time to sent_tx_control through a valid/ack/done handshake. It sits between the APB register block, which writes the slot configuration, and sent_tx_control, which consumes id/data per serial message.

Parameters:
NUM_SLOTS, 4, number of message slots (2..16)
SLOT_W, 2, slot index width = clog2(NUM_SLOTS)
PERIOD_W, 8, width of repeat period in frames

Ports:
clk_tx  in  1  transmit clock
reset_tx  in  1  synchronous, active-high reset
cfg_wr_i  in  1  one-cycle slot configuration write strobe
cfg_slot_i  in  SLOT_W  slot being written
cfg_enable_i  in  1  slot enable
cfg_id_i  in  8  message ID
cfg_data_i  in  16  message data
cfg_period_i  in  PERIOD_W  repeat period in frames; 0 = one-shot
clr_overrun_i  in  1  clears all overrun flags
frame_tick_i  in  1  one-cycle pulse per completed SENT frame
msg_ack_i  in  1  control accepted the offered message
msg_done_i  in  1  control finished the serial message (16 or 18 frames)
msg_valid_o  out  1  message offered
msg_slot_o  out  SLOT_W  slot of the offered message
msg_id_o  out  8  offered ID
msg_data_o  out  16  offered data
busy_o  out  1  a message is in flight (BUSY state)
pending_o  out  NUM_SLOTS  per-slot pending flags
overrun_o  out  NUM_SLOTS  sticky: the slot expired while still pending

Behaviour:
- Clock and reset: one clock, clk_tx. reset_tx is synchronous and active-high.
- Reset: state IDLE, rr_ptr=0, all slots disabled with period 0, cnt 0, pending 0, overrun 0. All outputs read 0.
- cfg write to slot s:
  - Loads enable, id, data and period. cnt[s] is loaded with period.
  - pending[s] and overrun[s] are cleared.
  - If enable=1 and period=0, pending[s] is set in the same update (one-shot).
- On frame_tick_i, for each enabled slot with period≠0:
  - If cnt≤1: pending is set and cnt reloads to period. If pending was already 1, overrun[s] is set.
  - Otherwise cnt decrements.
  - One-shot slots ignore ticks.
- FSM states:
  - IDLE: if any pending bit is set, the rotating-priority pick selects the first pending slot at or after rr_ptr, wrapping. Its id/data/slot are latched into the output registers. msg_valid_o rises the next cycle (latency 1) and the FSM goes to OFFER.
  - OFFER: outputs are held stable until msg_ack_i. On ack: pending[slot] is cleared, a one-shot slot is disabled, rr_ptr becomes slot+1 mod NUM_SLOTS, msg_valid_o drops the next cycle, and the FSM goes to BUSY.
  - BUSY: busy_o=1. On msg_done_i the FSM goes to IDLE. Arbitration resumes the cycle after.
- Simultaneous events and boundaries:
  - Ack and a tick expiry on the same slot in the same cycle: the expiry wins, so pending stays 1 and no overrun is flagged.
  - cfg write to the offered slot while in OFFER without ack: the offer is withdrawn, msg_valid_o drops next cycle, and the FSM returns to IDLE to re-arbitrate.
  - Write and ack in the same cycle: ack wins. The latched snapshot is transmitted and the new config applies.
  - Disable or write during BUSY: the in-flight message completes from its snapshot.
  - msg_ack_i outside OFFER and msg_done_i outside BUSY are ignored.
  - clr_overrun_i and an overrun set in the same cycle: the set wins.
  - reset_tx mid-message: returns to the reset state the next edge. Control must also be reset.

Decomposition:
- Package sent_tx_pkg holds:
  - state enum: IDLE, OFFER, BUSY
  - ID width 8 and data width 16 constants
  - clog2 helper
- Sub-module sent_tx_rr_arb is combinational: pending vector + rr_ptr → grant_valid, grant_idx. It is reusable elsewhere in the TX path.

Test Plan:
- Reset, then slot0 written with enable=1, period=0, id=0x5A, data=0x1234 → msg_valid_o=1 one cycle after pending. Outputs read id 0x5A, data 0x1234, slot 0. Ack → slot0 disabled, busy_o=1. msg_done_i → IDLE, no re-offer.
- Slots 0, 1 and 2 with period 1, all pending together → grant order 0,1,2,0,… with rr_ptr wrapping after slot 2.
- Slot1 with period 3, and done withheld for 8 ticks → pending[1] set at ticks 3 and 6, overrun_o[1]=1 at tick 6. clr_overrun_i → 0.
- Tick expiry and ack on the same slot in the same cycle → pending stays 1, overrun stays 0, and the slot is re-offered after done.
- In OFFER for slot2, cfg write to slot2 with data=0xBEEF and no ack → msg_valid_o drops, then is re-offered with 0xBEEF. Write with simultaneous ack → old data is held and BUSY is entered.
- reset_tx asserted in BUSY → the next cycle shows all outputs 0 and state IDLE. A late msg_done_i is ignored.

Source files
------------

// File: rtl/sent_tx_pkg.sv
// Shared types and helpers for the SENT transmit path.
package sent_tx_pkg;

   localparam int unsigned ID_W   = 8;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      BUSY  = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 0;
      while ((64'd1 << w) < 64'(value)) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/sent_tx_rr_arb.sv
// Combinational rotating-priority arbiter: first pending index at or after the pointer, wrapping.
module sent_tx_rr_arb
   import sent_tx_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = clog2(N)
) (
   input  logic [N-1:0]     i_pending,
   input  logic [IDX_W-1:0] i_rr_ptr,
   output logic             o_grant_valid,
   output logic [IDX_W-1:0] o_grant_idx
);

   logic             w_found_hi;
   logic             w_found_lo;
   logic [IDX_W-1:0] w_idx_hi;
   logic [IDX_W-1:0] w_idx_lo;

   // Lowest pending at/above the pointer wins; otherwise wrap to the lowest pending overall.
   always_comb begin
      w_found_hi = 1'b0;
      w_found_lo = 1'b0;
      w_idx_hi   = '0;
      w_idx_lo   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!w_found_hi && i_pending[i] && (IDX_W'(i) >= i_rr_ptr)) begin
            w_found_hi = 1'b1;
            w_idx_hi   = IDX_W'(i);
         end
         if (!w_found_lo && i_pending[i]) begin
            w_found_lo = 1'b1;
            w_idx_lo   = IDX_W'(i);
         end
      end
      o_grant_valid = w_found_lo;
      o_grant_idx   = w_found_hi ? w_idx_hi : w_idx_lo;
   end

endmodule

// File: rtl/sent_tx_slow_sched.sv
// Slow-channel message scheduler: per-slot repeat timers, round-robin pick, and a
// valid/ack/done handshake towards sent_tx_control.
module sent_tx_slow_sched
   import sent_tx_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 4,
   parameter int unsigned SLOT_W    = clog2(NUM_SLOTS),
   parameter int unsigned PERIOD_W  = 8
) (
   input  logic                 clk_tx,
   input  logic                 reset_tx,
   input  logic                 cfg_wr_i,
   input  logic [SLOT_W-1:0]    cfg_slot_i,
   input  logic                 cfg_enable_i,
   input  logic [ID_W-1:0]      cfg_id_i,
   input  logic [DATA_W-1:0]    cfg_data_i,
   input  logic [PERIOD_W-1:0]  cfg_period_i,
   input  logic                 clr_overrun_i,
   input  logic                 frame_tick_i,
   input  logic                 msg_ack_i,
   input  logic                 msg_done_i,
   output logic                 msg_valid_o,
   output logic [SLOT_W-1:0]    msg_slot_o,
   output logic [ID_W-1:0]      msg_id_o,
   output logic [DATA_W-1:0]    msg_data_o,
   output logic                 busy_o,
   output logic [NUM_SLOTS-1:0] pending_o,
   output logic [NUM_SLOTS-1:0] overrun_o
);

   logic [NUM_SLOTS-1:0] r_en;
   logic [NUM_SLOTS-1:0] r_pend;
   logic [NUM_SLOTS-1:0] r_ovr;
   logic [ID_W-1:0]      r_id     [NUM_SLOTS];
   logic [DATA_W-1:0]    r_data   [NUM_SLOTS];
   logic [PERIOD_W-1:0]  r_period [NUM_SLOTS];
   logic [PERIOD_W-1:0]  r_cnt    [NUM_SLOTS];

   state_t               r_state;
   logic [SLOT_W-1:0]    r_rr;
   logic                 r_valid;
   logic [SLOT_W-1:0]    r_slot;
   logic [ID_W-1:0]      r_id_out;
   logic [DATA_W-1:0]    r_data_out;

   logic                 w_grant_valid;
   logic [SLOT_W-1:0]    w_grant_idx;
   logic                 w_ack;
   logic                 w_wr_offered;
   logic [NUM_SLOTS-1:0] w_wr_hit;
   logic [NUM_SLOTS-1:0] w_ack_hit;
   logic [NUM_SLOTS-1:0] w_ticking;
   logic [NUM_SLOTS-1:0] w_expire;

   sent_tx_rr_arb #(
      .N     (NUM_SLOTS),
      .IDX_W (SLOT_W)
   ) u_arb (
      .i_pending     (r_pend),
      .i_rr_ptr      (r_rr),
      .o_grant_valid (w_grant_valid),
      .o_grant_idx   (w_grant_idx)
   );

   always_comb begin
      w_ack        = (r_state == OFFER) && msg_ack_i;
      w_wr_offered = cfg_wr_i && (cfg_slot_i == r_slot);
      w_wr_hit     = '0;
      w_ack_hit    = '0;
      w_ticking    = '0;
      w_expire     = '0;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
         w_wr_hit[s]  = cfg_wr_i && (cfg_slot_i == SLOT_W'(s));
         w_ack_hit[s] = w_ack && (r_slot == SLOT_W'(s));
         w_ticking[s] = frame_tick_i && r_en[s] && (r_period[s] != '0);
         w_expire[s]  = w_ticking[s] && (r_cnt[s] <= PERIOD_W'(1));
      end
   end

   // Slot state: a config write overrides everything else on that slot in the same cycle;
   // an expiry beats an ack's pending clear, and an overrun set beats the clear strobe.
   always_ff @(posedge clk_tx) begin
      if (reset_tx) begin
         r_en   <= '0;
         r_pend <= '0;
         r_ovr  <= '0;
         for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            r_id[s]     <= '0;
            r_data[s]   <= '0;
            r_period[s] <= '0;
            r_cnt[s]    <= '0;
         end
      end else begin
         for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            if (w_wr_hit[s]) begin
               r_en[s]     <= cfg_enable_i;
               r_id[s]     <= cfg_id_i;
               r_data[s]   <= cfg_data_i;
               r_period[s] <= cfg_period_i;
               r_cnt[s]    <= cfg_period_i;
               r_pend[s]   <= cfg_enable_i && (cfg_period_i == '0);
               r_ovr[s]    <= 1'b0;
            end else begin
               if (w_ticking[s]) begin
                  r_cnt[s] <= w_expire[s] ? r_period[s] : r_cnt[s] - PERIOD_W'(1);
               end
               if (w_expire[s]) begin
                  r_pend[s] <= 1'b1;
               end else if (w_ack_hit[s]) begin
                  r_pend[s] <= 1'b0;
               end
               if (w_ack_hit[s] && (r_period[s] == '0)) begin
                  r_en[s] <= 1'b0;
               end
               if (w_expire[s] && r_pend[s] && !w_ack_hit[s]) begin
                  r_ovr[s] <= 1'b1;
               end else if (clr_overrun_i) begin
                  r_ovr[s] <= 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_tx) begin
      if (reset_tx) begin
         r_state    <= IDLE;
         r_rr       <= '0;
         r_valid    <= 1'b0;
         r_slot     <= '0;
         r_id_out   <= '0;
         r_data_out <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_valid) begin
                  r_slot     <= w_grant_idx;
                  r_id_out   <= r_id[w_grant_idx];
                  r_data_out <= r_data[w_grant_idx];
                  r_valid    <= 1'b1;
                  r_state    <= OFFER;
               end
            end
            OFFER: begin
               if (msg_ack_i) begin
                  r_valid <= 1'b0;
                  r_rr    <= (r_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : r_slot + SLOT_W'(1);
                  r_state <= BUSY;
               end else if (w_wr_offered) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            BUSY: begin
               if (msg_done_i) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign msg_valid_o = r_valid;
   assign msg_slot_o  = r_slot;
   assign msg_id_o    = r_id_out;
   assign msg_data_o  = r_data_out;
   assign busy_o      = (r_state == BUSY);
   assign pending_o   = r_pend;
   assign overrun_o   = r_ovr;

endmodule

// File: tb/tb_sent_tx_slow_sched.sv
// Bench for sent_tx_slow_sched: directed scenarios plus random traffic against a behavioural model.
module tb_sent_tx_slow_sched;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_wr;
   logic [1:0]  cfg_slot;
   logic        cfg_en;
   logic [7:0]  cfg_id;
   logic [15:0] cfg_data;
   logic [7:0]  cfg_period;
   logic        clr, tick, ack, done;

   logic        msg_valid_o;
   logic [1:0]  msg_slot_o;
   logic [7:0]  msg_id_o;
   logic [15:0] msg_data_o;
   logic        busy_o;
   logic [3:0]  pending_o;
   logic [3:0]  overrun_o;
   logic [35:0] w_dut;

   int n_total = 0;
   int n_pass  = 0;

   // Model state: what each slot holds and what the scheduler is doing.
   bit          m_en   [N];
   logic [7:0]  m_id   [N];
   logic [15:0] m_data [N];
   int          m_per  [N];
   int          m_cnt  [N];
   bit          m_pend [N];
   bit          m_ovr  [N];
   bit          m_offering, m_busy, m_valid;
   int          m_rr, m_slot;
   logic [7:0]  m_oid;
   logic [15:0] m_odata;

   sent_tx_slow_sched #(.NUM_SLOTS(4), .SLOT_W(2), .PERIOD_W(8)) dut (
      .clk_tx(clk), .reset_tx(rst), .cfg_wr_i(cfg_wr), .cfg_slot_i(cfg_slot),
      .cfg_enable_i(cfg_en), .cfg_id_i(cfg_id), .cfg_data_i(cfg_data),
      .cfg_period_i(cfg_period), .clr_overrun_i(clr), .frame_tick_i(tick),
      .msg_ack_i(ack), .msg_done_i(done), .msg_valid_o(msg_valid_o),
      .msg_slot_o(msg_slot_o), .msg_id_o(msg_id_o), .msg_data_o(msg_data_o),
      .busy_o(busy_o), .pending_o(pending_o), .overrun_o(overrun_o)
   );

   assign w_dut = {msg_valid_o, msg_slot_o, msg_id_o, msg_data_o, busy_o, pending_o, overrun_o};

   always #5 clk = ~clk;

   function automatic logic [35:0] model_outs();
      logic [3:0] p, o;
      for (int i = 0; i < N; i++) begin
         p[i] = m_pend[i];
         o[i] = m_ovr[i];
      end
      return {m_valid, 2'(m_slot), m_oid, m_odata, m_busy, p, o};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_en[i] = 0; m_id[i] = '0; m_data[i] = '0; m_per[i] = 0;
         m_cnt[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
      end
      m_offering = 0; m_busy = 0; m_valid = 0; m_rr = 0; m_slot = 0;
      m_oid = '0; m_odata = '0;
   endtask

   // One clock of the scheduler, applied from the behaviour rules using the pre-edge inputs.
   task automatic model_step();
      bit acked, expired, ovr_set, found;
      int acked_slot, pick;
      if (rst) begin
         model_reset();
         return;
      end
      acked      = m_offering && ack;
      acked_slot = m_slot;
      if (m_busy) begin
         if (done) m_busy = 0;
      end else if (m_offering) begin
         if (ack) begin
            m_offering = 0; m_valid = 0; m_busy = 1;
            m_rr = (m_slot + 1) % N;
         end else if (cfg_wr && int'(cfg_slot) == m_slot) begin
            m_offering = 0; m_valid = 0;
         end
      end else begin
         found = 0;
         pick  = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && m_pend[(m_rr + k) % N]) begin
               found = 1;
               pick  = (m_rr + k) % N;
            end
         end
         if (found) begin
            m_slot = pick; m_oid = m_id[pick]; m_odata = m_data[pick];
            m_valid = 1; m_offering = 1;
         end
      end
      for (int s = 0; s < N; s++) begin
         if (cfg_wr && int'(cfg_slot) == s) begin
            m_en[s] = cfg_en; m_id[s] = cfg_id; m_data[s] = cfg_data;
            m_per[s] = int'(cfg_period); m_cnt[s] = int'(cfg_period);
            m_pend[s] = cfg_en && (cfg_period == 0);
            m_ovr[s] = 0;
         end else begin
            expired = 0;
            ovr_set = 0;
            if (tick && m_en[s] && m_per[s] != 0) begin
               if (m_cnt[s] <= 1) begin
                  expired  = 1;
                  ovr_set  = m_pend[s] && !(acked && acked_slot == s);
                  m_pend[s] = 1;
                  m_cnt[s]  = m_per[s];
               end else begin
                  m_cnt[s] = m_cnt[s] - 1;
               end
            end
            if (!expired && acked && acked_slot == s) m_pend[s] = 0;
            if (acked && acked_slot == s && m_per[s] == 0) m_en[s] = 0;
            if (ovr_set) m_ovr[s] = 1;
            else if (clr) m_ovr[s] = 0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      cfg_wr = 0; tick = 0; ack = 0; done = 0; clr = 0;
   endtask

   task automatic set_cfg(input int slot, input bit en, input logic [7:0] id,
                          input logic [15:0] data, input int period);
      cfg_wr = 1; cfg_slot = 2'(slot); cfg_en = en; cfg_id = id;
      cfg_data = data; cfg_period = 8'(period);
   endtask

   task automatic do_reset();
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      step();
      step();
      n_total++;
      if (w_dut !== 36'h0) $display("FAIL reset_outputs: got %h expected %h", w_dut, 36'h0);
      else n_pass++;
      rst = 0;
      step();
      n_total++;
      if (w_dut !== model_outs()) $display("FAIL reset_idle: got %h expected %h", w_dut, model_outs());
      else n_pass++;
   endtask

   task automatic test_one_shot();
      do_reset();
      set_cfg(0, 1, 8'h5A, 16'h1234, 0);
      step();
      n_total++;
      if ({msg_valid_o, pending_o} !== {1'b0, 4'b0001})
         $display("FAIL oneshot_pending: got %b expected %b", {msg_valid_o, pending_o}, 5'b00001);
      else n_pass++;
      step();
      n_total++;
      if ({msg_valid_o, msg_slot_o, msg_id_o, msg_data_o} !== {1'b1, 2'd0, 8'h5A, 16'h1234})
         $display("FAIL oneshot_offer: got %h expected %h",
                  {msg_valid_o, msg_slot_o, msg_id_o, msg_data_o}, {1'b1, 2'd0, 8'h5A, 16'h1234});
      else n_pass++;
      ack = 1;
      step();
      n_total++;
      if ({busy_o, msg_valid_o, pending_o} !== {1'b1, 1'b0, 4'b0000})
         $display("FAIL oneshot_busy: got %b expected %b", {busy_o, msg_valid_o, pending_o}, 6'b100000);
      else n_pass++;
      done = 1;
      step();
      for (int i = 0; i < 4; i++) step();
      n_total++;
      if ({msg_valid_o, busy_o} !== 2'b00 || w_dut !== model_outs())
         $display("FAIL oneshot_no_reoffer: got %h expected %h", w_dut, model_outs());
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int exp_order[6] = '{0, 1, 2, 0, 1, 2};
      int w;
      do_reset();
      for (int s = 0; s < 3; s++) begin
         set_cfg(s, 1, 8'(8'h10 + s), 16'(16'hA000 + s), 1);
         step();
      end
      tick = 1;
      step();
      for (int r = 0; r < 6; r++) begin
         w = 0;
         while (msg_valid_o !== 1'b1 && w < 10) begin
            step();
            w++;
         end
         n_total++;
         if (msg_valid_o !== 1'b1 || msg_slot_o !== 2'(exp_order[r]) || w_dut !== model_outs())
            $display("FAIL rr_grant_%0d: got valid=%b slot=%0d expected valid=1 slot=%0d",
                     r, msg_valid_o, msg_slot_o, exp_order[r]);
         else n_pass++;
         ack = 1;
         step();
         tick = 1; done = 1;
         step();
      end
   endtask

   task automatic test_overrun();
      do_reset();
      set_cfg(1, 1, 8'h31, 16'h3131, 3);
      step();
      for (int t = 1; t <= 8; t++) begin
         tick = 1;
         step();
         n_total++;
         if (pending_o[1] !== (t >= 3) || overrun_o[1] !== (t >= 6) || w_dut !== model_outs())
            $display("FAIL overrun_tick_%0d: got pend=%b ovr=%b expected pend=%b ovr=%b",
                     t, pending_o[1], overrun_o[1], t >= 3, t >= 6);
         else n_pass++;
         step();
      end
      clr = 1;
      step();
      n_total++;
      if (overrun_o !== 4'b0000) $display("FAIL overrun_clear: got %b expected %b", overrun_o, 4'b0000);
      else n_pass++;
      ack = 1;
      step();
      done = 1;
      step();
   endtask

   task automatic test_ack_expiry();
      int w;
      do_reset();
      set_cfg(0, 1, 8'h44, 16'h4444, 2);
      step();
      tick = 1; step();
      tick = 1; step();
      step();
      tick = 1; step();
      tick = 1; ack = 1;
      step();
      n_total++;
      if ({pending_o[0], overrun_o[0], busy_o} !== 3'b101 || w_dut !== model_outs())
         $display("FAIL ack_expiry_same_cycle: got %b expected %b",
                  {pending_o[0], overrun_o[0], busy_o}, 3'b101);
      else n_pass++;
      done = 1;
      step();
      w = 0;
      while (msg_valid_o !== 1'b1 && w < 10) begin
         step();
         w++;
      end
      n_total++;
      if ({msg_valid_o, msg_slot_o} !== {1'b1, 2'd0})
         $display("FAIL ack_expiry_reoffer: got %b expected %b", {msg_valid_o, msg_slot_o}, 3'b100);
      else n_pass++;
      ack = 1; step();
      done = 1; step();
   endtask

   task automatic test_withdraw();
      do_reset();
      set_cfg(2, 1, 8'h22, 16'h1111, 0);
      step();
      step();
      set_cfg(2, 1, 8'h22, 16'hBEEF, 0);
      step();
      n_total++;
      if (msg_valid_o !== 1'b0 || w_dut !== model_outs())
         $display("FAIL withdraw_drop: got %b expected %b", msg_valid_o, 1'b0);
      else n_pass++;
      step();
      n_total++;
      if ({msg_valid_o, msg_slot_o, msg_data_o} !== {1'b1, 2'd2, 16'hBEEF})
         $display("FAIL withdraw_reoffer: got %h expected %h",
                  {msg_valid_o, msg_slot_o, msg_data_o}, {1'b1, 2'd2, 16'hBEEF});
      else n_pass++;
      set_cfg(2, 1, 8'h23, 16'hCAFE, 0);
      ack = 1;
      step();
      n_total++;
      if ({busy_o, msg_data_o, pending_o[2]} !== {1'b1, 16'hBEEF, 1'b1} || w_dut !== model_outs())
         $display("FAIL write_with_ack: got %h expected %h",
                  {busy_o, msg_data_o, pending_o[2]}, {1'b1, 16'hBEEF, 1'b1});
      else n_pass++;
      done = 1;
      step();
      step();
      n_total++;
      if ({msg_valid_o, msg_id_o, msg_data_o} !== {1'b1, 8'h23, 16'hCAFE})
         $display("FAIL new_config_offer: got %h expected %h",
                  {msg_valid_o, msg_id_o, msg_data_o}, {1'b1, 8'h23, 16'hCAFE});
      else n_pass++;
   endtask

   task automatic test_reset_busy();
      do_reset();
      set_cfg(3, 1, 8'h77, 16'h7777, 0);
      step();
      step();
      ack = 1;
      step();
      rst = 1;
      step();
      rst = 0;
      n_total++;
      if (w_dut !== 36'h0) $display("FAIL reset_in_busy: got %h expected %h", w_dut, 36'h0);
      else n_pass++;
      done = 1;
      step();
      step();
      n_total++;
      if (w_dut !== 36'h0 || w_dut !== model_outs())
         $display("FAIL late_done_ignored: got %h expected %h", w_dut, 36'h0);
      else n_pass++;
   endtask

   task automatic test_random();
      int errs = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 15) == 0)
            set_cfg(int'($urandom_range(0, 3)), $urandom_range(0, 7) != 0, 8'($urandom),
                    16'($urandom), int'($urandom_range(0, 4)));
         tick = ($urandom_range(0, 3) == 0);
         ack  = ($urandom_range(0, 2) == 0);
         done = ($urandom_range(0, 3) == 0);
         clr  = ($urandom_range(0, 7) == 0);
         step();
         n_total++;
         if (w_dut !== model_outs()) begin
            errs++;
            if (errs <= 10)
               $display("FAIL random_cycle_%0d: got %h expected %h", c, w_dut, model_outs());
         end else n_pass++;
      end
   endtask

   initial begin
      rst = 1; cfg_wr = 0; cfg_slot = '0; cfg_en = 0; cfg_id = '0; cfg_data = '0;
      cfg_period = '0; clr = 0; tick = 0; ack = 0; done = 0;
      model_reset();
      test_reset();
      test_one_shot();
      test_round_robin();
      test_overrun();
      test_ack_expiry();
      test_withdraw();
      test_reset_busy();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
